// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : Parametrised UART transmitter with an input FIFO. Queued words
//               are sent back-to-back; frame is start, data LSB first,
//               optional parity, then one or two stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [DATA_BITS-1:0] DATA,
    output logic                 FULL,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 OVERRUN,
    output logic                 TX_LINE
);

    // Bit period in clock cycles, rounded to nearest.
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = AW + 1;

    localparam logic [CW-1:0] c_DIV_LAST  = CW'(DIV - 1);
    localparam logic [3:0]    c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [NW-1:0] c_DEPTH     = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [NW-1:0]        r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_par_bit;

    // Full is taken from the registered count, so a push while full is
    // rejected even when a pop happens on the same edge.
    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = START & ~w_full;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_par_bit = (PARITY == 1) ? ~(^w_head) : (^w_head);

    // Write side of the circular buffer; storage needs no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= DATA;
        end
    end

    // Pointers, occupancy count and overrun flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            OVERRUN  <= 1'b0;
        end else begin
            OVERRUN <= START & w_full;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + NW'(1);
                2'b01:   r_count <= r_count - NW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_idx;
    logic [3:0]           w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 w_shift_en;
    logic                 w_tx_nxt;
    logic                 w_done_nxt;
    logic                 w_wrap;

    // Every bit boundary falls on the wrap of the cycle counter.
    assign w_wrap = (r_cnt == c_DIV_LAST);

    // Next-state, line value, pop and completion decode.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tx_nxt    = TX_LINE;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                    w_idx_nxt   = 4'd0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    if (r_idx == c_DATA_LAST) begin
                        w_idx_nxt = 4'd0;
                        if (PARITY != 0) begin
                            w_state_nxt = S_PAR;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = S_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_idx_nxt  = r_idx + 4'd1;
                        w_shift_en = 1'b1;
                        w_tx_nxt   = r_shift[1];
                    end
                end
            end
            S_PAR: begin
                if (w_wrap) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    if (r_idx == c_STOP_LAST) begin
                        w_done_nxt = 1'b1;
                        w_idx_nxt  = 4'd0;
                        // Chain straight into the next start bit when work is queued.
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_tx_nxt    = 1'b0;
                            w_state_nxt = S_START;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // FSM state, bit timing, shift register and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= 4'd0;
            r_shift <= '0;
            r_par   <= 1'b0;
            TX_LINE <= 1'b1;
            DONE    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            TX_LINE <= w_tx_nxt;
            DONE    <= w_done_nxt;
            if ((r_state == S_IDLE) || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            // Capture at pop so the FIFO slot frees immediately.
            if (w_pop) begin
                r_shift <= w_head;
                r_par   <= w_par_bit;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

    assign FULL = w_full;
    assign BUSY = (r_state != S_IDLE) | ~w_empty;

endmodule
`default_nettype wire
